// File: rtl/writeback_queue.sv
// In-order writeback queue merging MEM and ALU results into one register-file write port.
// Optional forwarding of pending writes to SR1/SR2 is compiled in with `define WB_BYPASS_EN.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         MEM_Valid,
  input  logic [4:0]                   MEM_DR,
  input  logic [XLEN-1:0]              MEM_Data,
  output logic                         MEM_Ready,
  input  logic                         ALU_Valid,
  input  logic [4:0]                   ALU_DR,
  input  logic [XLEN-1:0]              ALU_Data,
  output logic                         ALU_Ready,
  input  logic                         RF_Stall,
  output logic                         RegW,
  output logic [4:0]                   DR,
  output logic [XLEN-1:0]              Reg_In,
  input  logic [4:0]                   SR1,
  input  logic [4:0]                   SR2,
  output logic                         Fwd1_Hit,
  output logic [XLEN-1:0]              Fwd1_Data,
  output logic                         Fwd2_Hit,
  output logic [XLEN-1:0]              Fwd2_Data,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Empty,
  output logic                         Full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [4:0]      dr_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic            empty, full, pop, space, mem_acc, alu_acc, push;
  logic [4:0]      in_dr;
  logic [XLEN-1:0] in_data;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    // Reset blocks the write port so a pending head is never written while RST is high.
    pop     = !empty && !RF_Stall && !RST;
    space   = !full || pop;
    mem_acc = MEM_Valid && space;
    alu_acc = ALU_Valid && space && !MEM_Valid;
    in_dr   = mem_acc ? MEM_DR : ALU_DR;
    in_data = mem_acc ? MEM_Data : ALU_Data;
    push    = (mem_acc || alu_acc) && (in_dr != 5'd0) && !RST;

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      dr_mem[wr_ptr_q]   <= in_dr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

  assign MEM_Ready = space;
  assign ALU_Ready = space && !MEM_Valid;
  assign RegW      = pop;
  assign DR        = pop ? dr_mem[rd_ptr_q] : 5'd0;
  assign Reg_In    = pop ? data_mem[rd_ptr_q] : '0;
  assign Count     = count_q;
  assign Empty     = empty;
  assign Full      = full;

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0] match1, match2;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PW-1:0] age;
    logic          live;
    assign age        = PW'(gi) - rd_ptr_q;
    assign live       = (CW'(age) < count_q);
    assign match1[gi] = live && (SR1 != 5'd0) && (dr_mem[gi] == SR1);
    assign match2[gi] = live && (SR2 != 5'd0) && (dr_mem[gi] == SR2);
  end

  // Scan oldest to youngest so the last match seen is the youngest writer.
  always_comb begin
    Fwd1_Hit  = 1'b0;
    Fwd1_Data = '0;
    Fwd2_Hit  = 1'b0;
    Fwd2_Data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[rd_ptr_q + PW'(k)]) begin
        Fwd1_Hit  = 1'b1;
        Fwd1_Data = data_mem[rd_ptr_q + PW'(k)];
      end
      if (match2[rd_ptr_q + PW'(k)]) begin
        Fwd2_Hit  = 1'b1;
        Fwd2_Data = data_mem[rd_ptr_q + PW'(k)];
      end
    end
  end
`else
  logic unused_sr;
  assign unused_sr = ^{SR1, SR2};
  assign Fwd1_Hit  = 1'b0;
  assign Fwd1_Data = '0;
  assign Fwd2_Hit  = 1'b0;
  assign Fwd2_Data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a per-cycle vector table plus hand-written reset sequences.
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int NV    = 27;

  logic             CLK = 1'b0;
  logic             RST;
  logic             MEM_Valid, ALU_Valid, RF_Stall;
  logic [4:0]       MEM_DR, ALU_DR, SR1, SR2, DR;
  logic [XLEN-1:0]  MEM_Data, ALU_Data, Reg_In, Fwd1_Data, Fwd2_Data;
  logic             MEM_Ready, ALU_Ready, RegW, Fwd1_Hit, Fwd2_Hit, Empty, Full;
  logic [2:0]       Count;

  writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_Valid(MEM_Valid), .MEM_DR(MEM_DR), .MEM_Data(MEM_Data), .MEM_Ready(MEM_Ready),
    .ALU_Valid(ALU_Valid), .ALU_DR(ALU_DR), .ALU_Data(ALU_Data), .ALU_Ready(ALU_Ready),
    .RF_Stall(RF_Stall), .RegW(RegW), .DR(DR), .Reg_In(Reg_In),
    .SR1(SR1), .SR2(SR2),
    .Fwd1_Hit(Fwd1_Hit), .Fwd1_Data(Fwd1_Data), .Fwd2_Hit(Fwd2_Hit), .Fwd2_Data(Fwd2_Data),
    .Count(Count), .Empty(Empty), .Full(Full)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mv;  logic [4:0] mdr; logic [31:0] md;
    logic        av;  logic [4:0] adr; logic [31:0] ad;
    logic        st;  logic [4:0] s1;  logic [4:0]  s2;
    logic        e_regw; logic [4:0] e_dr; logic [31:0] e_data;
    logic        e_mr; logic e_ar; logic [2:0] e_cnt;
    logic        e_f1; logic [31:0] e_f1d;
    logic        e_f2; logic [31:0] e_f2d;
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mdr, input logic [31:0] md,
                       input logic av, input logic [4:0] adr, input logic [31:0] ad,
                       input logic st, input logic [4:0] s1, input logic [4:0] s2);
    MEM_Valid = mv; MEM_DR = mdr; MEM_Data = md;
    ALU_Valid = av; ALU_DR = adr; ALU_Data = ad;
    RF_Stall = st; SR1 = s1; SR2 = s2;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic        f1, f2;
    logic [31:0] f1d, f2d;
`ifdef WB_BYPASS_EN
    f1 = v.e_f1; f1d = v.e_f1d; f2 = v.e_f2; f2d = v.e_f2d;
`else
    f1 = 1'b0; f1d = 32'd0; f2 = 1'b0; f2d = 32'd0;
`endif
    chk("regw",      i, 32'(RegW),      32'(v.e_regw));
    chk("dr",        i, 32'(DR),        32'(v.e_dr));
    chk("reg_in",    i, Reg_In,         v.e_data);
    chk("mem_ready", i, 32'(MEM_Ready), 32'(v.e_mr));
    chk("alu_ready", i, 32'(ALU_Ready), 32'(v.e_ar));
    chk("count",     i, 32'(Count),     32'(v.e_cnt));
    chk("empty",     i, 32'(Empty),     32'(v.e_cnt == 3'd0));
    chk("full",      i, 32'(Full),      32'(v.e_cnt == 3'd4));
    chk("fwd1_hit",  i, 32'(Fwd1_Hit),  32'(f1));
    chk("fwd1_data", i, Fwd1_Data,      f1d);
    chk("fwd2_hit",  i, 32'(Fwd2_Hit),  32'(f2));
    chk("fwd2_data", i, Fwd2_Data,      f2d);
  endtask

  initial begin
    // mv mdr md | av adr ad | st s1 s2 | regw dr data | mr ar cnt | f1 f1d f2 f2d
    vecs[0]  = '{0,0,0,           0,0,0,          0,0,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[1]  = '{0,0,0,           1,5,32'hDEADBEEF,0,0,0, 0,0,0,           1,1,0, 0,0,0,0};
    vecs[2]  = '{0,0,0,           0,0,0,          0,0,0, 1,5,32'hDEADBEEF, 1,1,1, 0,0,0,0};
    vecs[3]  = '{0,0,0,           0,0,0,          0,0,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[4]  = '{1,3,32'h11,      1,4,32'h22,     0,0,0, 0,0,0,            1,0,0, 0,0,0,0};
    vecs[5]  = '{0,0,0,           1,4,32'h22,     0,0,0, 1,3,32'h11,       1,1,1, 0,0,0,0};
    vecs[6]  = '{0,0,0,           0,0,0,          0,0,0, 1,4,32'h22,       1,1,1, 0,0,0,0};
    vecs[7]  = '{0,0,0,           0,0,0,          0,0,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[8]  = '{1,0,32'hFFFFFFFF,0,0,0,          0,0,0, 0,0,0,            1,0,0, 0,0,0,0};
    vecs[9]  = '{0,0,0,           0,0,0,          0,0,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[10] = '{0,0,0,           1,7,32'hA,      1,7,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[11] = '{0,0,0,           1,7,32'hB,      1,7,0, 0,0,0,            1,1,1, 1,32'hA,0,0};
    vecs[12] = '{0,0,0,           0,0,0,          1,7,0, 0,0,0,            1,1,2, 1,32'hB,0,0};
    vecs[13] = '{0,0,0,           0,0,0,          0,7,0, 1,7,32'hA,        1,1,2, 1,32'hB,0,0};
    vecs[14] = '{0,0,0,           0,0,0,          0,0,7, 1,7,32'hB,        1,1,1, 0,0,1,32'hB};
    vecs[15] = '{0,0,0,           0,0,0,          0,0,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[16] = '{0,0,0,           1,1,32'h101,    1,0,0, 0,0,0,            1,1,0, 0,0,0,0};
    vecs[17] = '{0,0,0,           1,2,32'h102,    1,0,0, 0,0,0,            1,1,1, 0,0,0,0};
    vecs[18] = '{0,0,0,           1,3,32'h103,    1,0,0, 0,0,0,            1,1,2, 0,0,0,0};
    vecs[19] = '{0,0,0,           1,4,32'h104,    1,0,0, 0,0,0,            1,1,3, 0,0,0,0};
    vecs[20] = '{0,0,0,           1,5,32'h105,    1,0,0, 0,0,0,            0,0,4, 0,0,0,0};
    vecs[21] = '{0,0,0,           1,5,32'h105,    0,0,0, 1,1,32'h101,      1,1,4, 0,0,0,0};
    vecs[22] = '{0,0,0,           0,0,0,          0,0,0, 1,2,32'h102,      1,1,4, 0,0,0,0};
    vecs[23] = '{0,0,0,           0,0,0,          0,0,0, 1,3,32'h103,      1,1,3, 0,0,0,0};
    vecs[24] = '{0,0,0,           0,0,0,          0,0,0, 1,4,32'h104,      1,1,2, 0,0,0,0};
    vecs[25] = '{0,0,0,           0,0,0,          0,0,0, 1,5,32'h105,      1,1,1, 0,0,0,0};
    vecs[26] = '{0,0,0,           0,0,0,          0,0,0, 0,0,0,            1,1,0, 0,0,0,0};

    RST = 1'b1;
    drive(1, 6, 32'h66, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_regw",  -1, 32'(RegW),  32'd0);
    chk("rst_count", -1, 32'(Count), 32'd0);
    chk("rst_empty", -1, 32'(Empty), 32'd1);
    chk("rst_full",  -1, 32'(Full),  32'd0);
    chk("rst_dr",    -1, 32'(DR),    32'd0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].mv, vecs[i].mdr, vecs[i].md, vecs[i].av, vecs[i].adr, vecs[i].ad,
            vecs[i].st, vecs[i].s1, vecs[i].s2);
      #1;
      check_vec(i, vecs[i]);
      $display("step=%0d regw=%0b dr=%0d reg_in=0x%0h count=%0d", i, RegW, DR, Reg_In, Count);
      @(negedge CLK);
    end

    // Reset arriving while the queue is draining three stalled entries.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 5'(9 + k), 32'h900 + k, 1, 0, 0);
      @(negedge CLK);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drain_regw",  100, 32'(RegW),  32'd1);
    chk("drain_dr",    100, 32'(DR),    32'd9);
    chk("drain_count", 100, 32'(Count), 32'd3);
    $display("step=100 regw=%0b dr=%0d count=%0d", RegW, DR, Count);
    @(negedge CLK);
    RST = 1'b1;
    drive(1, 12, 32'hC, 0, 0, 0, 0, 9, 10);
    #1;
    chk("inrst_regw",   101, 32'(RegW),   32'd0);
    chk("inrst_dr",     101, 32'(DR),     32'd0);
    chk("inrst_reg_in", 101, Reg_In,      32'd0);
    $display("step=101 regw=%0b dr=%0d count=%0d", RegW, DR, Count);
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 9, 12);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_count",     102 + k, 32'(Count),     32'd0);
      chk("post_regw",      102 + k, 32'(RegW),      32'd0);
      chk("post_empty",     102 + k, 32'(Empty),     32'd1);
      chk("post_full",      102 + k, 32'(Full),      32'd0);
      chk("post_mem_ready", 102 + k, 32'(MEM_Ready), 32'd1);
      chk("post_alu_ready", 102 + k, 32'(ALU_Ready), 32'd1);
      chk("post_fwd1_hit",  102 + k, 32'(Fwd1_Hit),  32'd0);
      chk("post_fwd2_hit",  102 + k, 32'(Fwd2_Hit),  32'd0);
      $display("step=%0d regw=%0b count=%0d", 102 + k, RegW, Count);
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries; SHALL be a power of two, at least 2.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 MEM_Valid  input  1  load-unit writeback request.
REQ-006 MEM_DR  input  5  load destination register.
REQ-007 MEM_Data  input  XLEN  load result.
REQ-008 MEM_Ready  output  1  load request accepted this cycle when high with MEM_Valid.
REQ-009 ALU_Valid, ALU_DR, ALU_Data, ALU_Ready  input/input/input/output  1/5/XLEN/1  ALU request port, same semantics as the MEM port.
REQ-010 RF_Stall  input  1  register-file write port unavailable this cycle.
REQ-011 RegW, DR, Reg_In  output  1/5/XLEN  register-file write port drive.
REQ-012 SR1, SR2  input  5  source registers probed for pending writes.
REQ-013 Fwd1_Hit, Fwd1_Data, Fwd2_Hit, Fwd2_Data  output  1/XLEN/1/XLEN  forwarding results for SR1, SR2.
REQ-014 Count  output  $clog2(DEPTH+1)  occupied entries; Empty, Full  output  1  Count==0, Count==DEPTH.

Function
- REQ-015 Queue is in-order FIFO: entries SHALL drain in acceptance order.
- REQ-016 Pop: RegW SHALL equal !Empty && !RF_Stall; when RegW is high, DR/Reg_In SHALL equal the head entry and the head SHALL be removed at that edge.
- REQ-017 DR and Reg_In SHALL be 0 whenever RegW is low.
- REQ-018 Space: Space = !Full || RegW; enqueue and pop in the same cycle at Full SHALL be legal.
- REQ-019 MEM_Ready SHALL equal Space; ALU_Ready SHALL equal Space && !MEM_Valid (MEM fixed priority, at most one accept per cycle).
- REQ-020 Accepted request with DR != 0 SHALL be enqueued at that edge; accepted request with DR == 0 SHALL be acknowledged and discarded (x0 never written).
- REQ-021 Latency: request accepted in cycle N on empty, unstalled queue SHALL produce RegW high with its data in cycle N+1.
- REQ-022 Count SHALL change by +1 on enqueue only, -1 on pop only, 0 on both or neither; pointers SHALL wrap modulo DEPTH.
- REQ-023 ALU request not accepted SHALL be held by source; block SHALL NOT latch unaccepted data.
- REQ-024 RF_Stall high SHALL freeze the head with no RegW; enqueue continues until Full.

Reset
- REQ-025 RST high at an edge SHALL empty the queue (Count=0, pointers=0), discarding pending entries, even mid-drain.
- REQ-026 During and the cycle after reset: RegW=0, DR=0, Reg_In=0, Empty=1, Full=0, Fwd hits=0, MEM_Ready=ALU_Ready=1 per REQ-019 once RST is low.
- REQ-027 Requests presented while RST is high SHALL NOT be enqueued.

Configuration
- REQ-028 Macro WB_BYPASS_EN compiles forwarding in or out.
- REQ-029 Defined: FwdN_Hit SHALL be high when SRN != 0 matches a valid queued entry's DR; FwdN_Data SHALL be the youngest matching entry's data; the head popping this cycle still counts; same-cycle incoming requests SHALL NOT hit.
- REQ-030 Defined: FwdN_Data SHALL be 0 when FwdN_Hit is low.
- REQ-031 Not defined: Fwd1_Hit, Fwd2_Hit, Fwd1_Data, Fwd2_Data SHALL be constant 0 and no comparison logic SHALL exist.

Verification
- REQ-032 ALU_Valid, ALU_DR=5, ALU_Data=0xDEADBEEF on empty queue -> ALU_Ready=1; next cycle RegW=1, DR=5, Reg_In=0xDEADBEEF; then Empty=1.
- REQ-033 MEM(DR=3,0x11) and ALU(DR=4,0x22) same cycle -> ALU_Ready=0, MEM enqueued; ALU held, accepted next cycle; writes drain 3 then 4.
- REQ-034 RF_Stall=1, push 5 requests (DEPTH=4) -> 4 accepted, Full=1, Ready=0; drop RF_Stall -> same-cycle pop+push accepted, 5 writes in order.
- REQ-035 Request with DR=0, data 0xFFFFFFFF -> Ready=1, Count unchanged, RegW never high for it.
- REQ-036 WB_BYPASS_EN, stalled queue holds DR=7:0xA then DR=7:0xB, SR1=7, SR2=0 -> Fwd1_Hit=1, Fwd1_Data=0xB, Fwd2_Hit=0.
- REQ-037 Queue with 3 entries, RST pulsed while popping -> next cycle Count=0, RegW=0, no further writes.
